// File: rtl/seg7_pkg.sv
// ---------------------------------------------------------------------------
// seg7_pkg
// Shared definitions for the multiplexed seven-segment display driver:
//   - FSM state encoding for the load/convert handshake
//   - display mode encoding (decimal / hexadecimal)
//   - active-low segment codes {dp,g,f,e,d,c,b,a} and the double-dabble
//     nibble adjust helper
// No ports; imported by seg7_bin2bcd_seq and seg7_scan_display.
// ---------------------------------------------------------------------------
package seg7_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_CONV = 1'b1
    } state_e;

    typedef enum logic {
        MODE_DEC = 1'b0,
        MODE_HEX = 1'b1
    } mode_e;

    // Dash marks an overflowed decimal value; blank is a dark digit.
    localparam logic [7:0] SEG_DASH  = 8'hBF;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Active-low segment pattern for one hex digit. The dp bit stays 1.
    function automatic logic [7:0] seg_code(input logic [3:0] nib);
        logic [7:0] code;
        case (nib)
            4'h0: code = 8'hC0;
            4'h1: code = 8'hF9;
            4'h2: code = 8'hA4;
            4'h3: code = 8'hB0;
            4'h4: code = 8'h99;
            4'h5: code = 8'h92;
            4'h6: code = 8'h82;
            4'h7: code = 8'hF8;
            4'h8: code = 8'h80;
            4'h9: code = 8'h90;
            4'hA: code = 8'h88;
            4'hB: code = 8'h83;
            4'hC: code = 8'hC6;
            4'hD: code = 8'hA1;
            4'hE: code = 8'h86;
            default: code = 8'h8E;
        endcase
        return code;
    endfunction

    // Double-dabble correction: a BCD nibble of 5 or more gets +3 so that
    // the following left shift carries correctly into the next decade.
    function automatic logic [3:0] dd_adjust(input logic [3:0] nib);
        return (nib >= 4'd5) ? nib + 4'd3 : nib;
    endfunction

endpackage

// File: rtl/seg7_bin2bcd_seq.sv
// ---------------------------------------------------------------------------
// seg7_bin2bcd_seq
// Iterative double-dabble binary-to-BCD converter, one bit per clock.
// A start while idle latches the binary operand and runs BIN_WIDTH
// adjust-and-shift iterations. The result of the current iteration is
// exposed combinationally (bcd_next / ovf_next) together with 'done', so
// the parent can capture the final result on the very edge that performs
// the last iteration.
// Ports:
//   clk, rst    clock, synchronous active-high reset (aborts a conversion)
//   start       begin a conversion of 'bin' (ignored while busy)
//   bin         binary operand
//   busy        conversion in progress
//   done        this cycle's edge performs the last iteration
//   bcd_next    BCD value after this cycle's iteration (NUM_DIGITS nibbles)
//   ovf_next    sticky overflow after this cycle's iteration: a 1 has been
//               shifted out of the most significant BCD nibble
// ---------------------------------------------------------------------------
module seg7_bin2bcd_seq
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int BIN_WIDTH  = 24
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [BIN_WIDTH-1:0]    bin,
    output logic                    busy,
    output logic                    done,
    output logic [4*NUM_DIGITS-1:0] bcd_next,
    output logic                    ovf_next
);

    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int CNT_W = $clog2(BIN_WIDTH + 1);

    logic [BIN_WIDTH-1:0] shift_q;
    logic [BCD_W-1:0]     bcd_q;
    logic [BCD_W-1:0]     adj;
    logic                 ovf_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 busy_q;

    // Add-3 correction applied to every decade before the shift.
    always_comb begin
        adj = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            adj[4*i +: 4] = dd_adjust(bcd_q[4*i +: 4]);
        end
    end

    // The bit leaving the top nibble is lost from the register, so it is
    // folded into the sticky overflow flag instead.
    assign bcd_next = {adj[BCD_W-2:0], shift_q[BIN_WIDTH-1]};
    assign ovf_next = ovf_q | adj[BCD_W-1];
    assign done     = busy_q && (cnt_q == CNT_W'(1));
    assign busy     = busy_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q <= '0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else if (start && !busy_q) begin
            shift_q <= bin;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= CNT_W'(BIN_WIDTH);
            busy_q  <= 1'b1;
        end else if (busy_q) begin
            shift_q <= shift_q << 1;
            bcd_q   <= bcd_next;
            ovf_q   <= ovf_next;
            cnt_q   <= cnt_q - CNT_W'(1);
            if (done) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/seg7_scan_display.sv
// ---------------------------------------------------------------------------
// seg7_scan_display
// Multi-digit seven-segment driver. A load captures a binary value and
// converts it either sequentially to decimal (double-dabble, BIN_WIDTH
// cycles) or directly to hex (one cycle). The finished digits, overflow
// flag and leading-zero blank mask are committed together, so a partial
// result is never displayed. Digits are time-multiplexed at SCAN_HZ.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   on_off      1 = display enabled, 0 = all digits dark
//   mode        0 = decimal, 1 = hex (captured with load)
//   blank_lz    1 = blank leading zeros (captured with load)
//   load        capture 'value' when not busy
//   value       binary value to display
//   busy        conversion in progress
//   ovf         last decimal value did not fit in NUM_DIGITS digits
//   DIG         digit enables, active low, one-hot-zero while enabled
//   Y           segments {dp,g,f,e,d,c,b,a}, active low
// ---------------------------------------------------------------------------
module seg7_scan_display
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int BIN_WIDTH  = 24,
    parameter int CLK_HZ     = 100_000_000,
    parameter int SCAN_HZ    = 1_000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  on_off,
    input  logic                  mode,
    input  logic                  blank_lz,
    input  logic                  load,
    input  logic [BIN_WIDTH-1:0]  value,
    output logic                  busy,
    output logic                  ovf,
    output logic [NUM_DIGITS-1:0] DIG,
    output logic [7:0]            Y
);

    localparam int DISP_W   = 4 * NUM_DIGITS;
    localparam int PRESCALE = CLK_HZ / SCAN_HZ;
    localparam int PRE_W    = $clog2(PRESCALE);
    localparam int IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);

    state_e                state_q;
    mode_e                 mode_q;
    logic                  blank_q;
    logic [BIN_WIDTH-1:0]  value_q;
    logic                  busy_q;
    logic [DISP_W-1:0]     disp_q;
    logic [NUM_DIGITS-1:0] mask_q;
    logic                  ovf_q;

    logic [PRE_W-1:0]      pre_q;
    logic [IDX_W-1:0]      idx_q;
    logic [NUM_DIGITS-1:0] dig_q;
    logic [7:0]            y_q;

    logic                  accept;
    logic                  conv_start;
    logic                  conv_busy;
    logic                  conv_done;
    logic [DISP_W-1:0]     conv_bcd;
    logic                  conv_ovf;

    logic                  finish;
    logic [DISP_W-1:0]     hex_word;
    logic [DISP_W-1:0]     new_disp;
    logic                  new_ovf;
    logic [NUM_DIGITS-1:0] new_mask;
    logic                  seen;

    logic [3:0]            cur_digit;
    logic                  cur_dark;

    // A load is taken only from idle; loads during a conversion are dropped.
    assign accept     = (state_q == ST_IDLE) && !conv_busy && load;
    assign conv_start = accept && (mode == MODE_DEC);

    seg7_bin2bcd_seq #(
        .NUM_DIGITS (NUM_DIGITS),
        .BIN_WIDTH  (BIN_WIDTH)
    ) u_bin2bcd (
        .clk      (clk),
        .rst      (rst),
        .start    (conv_start),
        .bin      (value),
        .busy     (conv_busy),
        .done     (conv_done),
        .bcd_next (conv_bcd),
        .ovf_next (conv_ovf)
    );

    // Hex digits beyond the width of the value read as zero; extra value
    // bits beyond NUM_DIGITS nibbles are simply not shown.
    assign hex_word = DISP_W'(value_q);

    assign finish   = (state_q == ST_CONV) && ((mode_q == MODE_HEX) || conv_done);
    assign new_disp = (mode_q == MODE_HEX) ? hex_word : conv_bcd;
    assign new_ovf  = (mode_q == MODE_DEC) && conv_ovf;

    // Blank mask of the result being committed: scanning from the top,
    // every digit above the first non-zero one goes dark. Digit 0 always
    // stays lit and nothing is blanked while the dashes are shown.
    always_comb begin
        new_mask = '0;
        seen     = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (new_disp[4*i +: 4] != 4'd0) begin
                seen = 1'b1;
            end
            new_mask[i] = blank_q && !new_ovf && !seen;
        end
    end

    // Load/convert FSM. Display register, overflow and blank mask are
    // written together on the edge that completes the conversion.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_DEC;
            blank_q <= 1'b0;
            value_q <= '0;
            busy_q  <= 1'b0;
            disp_q  <= '0;
            mask_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        mode_q  <= mode_e'(mode);
                        blank_q <= blank_lz;
                        value_q <= value;
                        busy_q  <= 1'b1;
                        state_q <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    if (finish) begin
                        disp_q  <= new_disp;
                        ovf_q   <= new_ovf;
                        mask_q  <= new_mask;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Scan timebase: the digit index advances once per PRESCALE cycles,
    // independent of conversions and of on_off.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q <= '0;
            idx_q <= '0;
        end else if (pre_q == PRE_MAX) begin
            pre_q <= '0;
            idx_q <= (idx_q == IDX_MAX) ? '0 : idx_q + IDX_W'(1);
        end else begin
            pre_q <= pre_q + PRE_W'(1);
        end
    end

    // Digit currently selected by the scan index.
    always_comb begin
        cur_digit = 4'd0;
        cur_dark  = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_digit = disp_q[4*i +: 4];
                cur_dark  = mask_q[i];
            end
        end
    end

    // Registered pin drivers, one cycle behind the scan index.
    always_ff @(posedge clk) begin
        if (rst) begin
            dig_q <= '1;
            y_q   <= SEG_BLANK;
        end else if (!on_off) begin
            dig_q <= '1;
            y_q   <= SEG_BLANK;
        end else begin
            dig_q <= ~(NUM_DIGITS'(1) << idx_q);
            if (ovf_q) begin
                y_q <= SEG_DASH;
            end else if (cur_dark) begin
                y_q <= SEG_BLANK;
            end else begin
                y_q <= seg_code(cur_digit);
            end
        end
    end

    assign busy = busy_q;
    assign ovf  = ovf_q;
    assign DIG  = dig_q;
    assign Y    = y_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
// ---------------------------------------------------------------------------
// tb_seg7_scan_display
// Self-checking bench driving two display instances from the same inputs:
// an 8-digit one and a 4-digit one (for overflow), both with a scan
// prescale of 10 clocks. Expected digit codes come from a table of known
// cases and from an arithmetic reference model for random values.
// ---------------------------------------------------------------------------
module tb_seg7_scan_display;

    logic        clk = 1'b0;
    logic        rst;
    logic        on_off;
    logic        mode;
    logic        blank_lz;
    logic        load;
    logic [23:0] value;

    logic        busy8, ovf8, busy4, ovf4;
    logic [7:0]  dig8, y8, y4;
    logic [3:0]  dig4;

    int checks = 0;
    int errors = 0;

    logic [7:0] segTab [16];

    typedef struct {
        logic [23:0] value;
        logic        hex;
        logic        blank;
        int          busyCycles;
        logic [63:0] codes8;
        logic [31:0] codes4;
        logic        ovf4;
    } vec_t;

    vec_t vecs [8];

    always #5 clk = ~clk;

    seg7_scan_display #(
        .NUM_DIGITS (8),
        .BIN_WIDTH  (24),
        .CLK_HZ     (1000),
        .SCAN_HZ    (100)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .on_off   (on_off),
        .mode     (mode),
        .blank_lz (blank_lz),
        .load     (load),
        .value    (value),
        .busy     (busy8),
        .ovf      (ovf8),
        .DIG      (dig8),
        .Y        (y8)
    );

    seg7_scan_display #(
        .NUM_DIGITS (4),
        .BIN_WIDTH  (24),
        .CLK_HZ     (1000),
        .SCAN_HZ    (100)
    ) dut4 (
        .clk      (clk),
        .rst      (rst),
        .on_off   (on_off),
        .mode     (mode),
        .blank_lz (blank_lz),
        .load     (load),
        .value    (value),
        .busy     (busy4),
        .ovf      (ovf4),
        .DIG      (dig4),
        .Y        (y4)
    );

    // Compare one observed value against its expectation.
    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Pulse load for one clock, then count how many sampled cycles each
    // instance reports busy (bounded).
    task automatic applyStimulus(input logic [23:0] v, input logic hex, input logic blank,
                                 output int cyc8, output int cyc4);
        @(negedge clk);
        value    = v;
        mode     = hex;
        blank_lz = blank;
        load     = 1'b1;
        @(negedge clk);
        load = 1'b0;
        cyc8 = 0;
        cyc4 = 0;
        for (int c = 0; c < 100; c++) begin
            if (!busy8 && !busy4) break;
            if (busy8) cyc8++;
            if (busy4) cyc4++;
            @(negedge clk);
        end
    endtask

    // Watch a full scan round and collect the segment code shown for each
    // digit position.
    task automatic readDigits(output logic [63:0] c8, output logic [31:0] c4);
        logic [7:0] seen8;
        logic [3:0] seen4;
        int bad;
        c8    = '1;
        c4    = '1;
        seen8 = '0;
        seen4 = '0;
        bad   = 0;
        @(negedge clk);
        for (int s = 0; s < 90; s++) begin
            @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                if (dig8 == ~(8'd1 << i)) begin
                    c8[8*i +: 8] = y8;
                    seen8[i] = 1'b1;
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (dig4 == ~(4'd1 << i)) begin
                    c4[8*i +: 8] = y4;
                    seen4[i] = 1'b1;
                end
            end
            if ($countones(~dig8) != 1 || $countones(~dig4) != 1) bad++;
        end
        checkOutput("scanSeen8", seen8, 8'hFF);
        checkOutput("scanSeen4", seen4, 4'hF);
        checkOutput("digOneHotZero", bad, 0);
    endtask

    // Reference model: digits by repeated division, decimal overflow when
    // the value reaches 10^nd, leading-zero blanking above the top non-zero
    // digit. Returns nd codes, digit i in bits [8i+7:8i].
    function automatic logic [63:0] modelCodes(input int nd, input logic [23:0] v,
                                              input logic hex, input logic blank);
        longint lim;
        longint rest;
        int base;
        int d [8];
        int top;
        logic [63:0] r;
        lim  = 1;
        rest = longint'(v);
        base = hex ? 16 : 10;
        top  = 0;
        r    = '1;
        for (int i = 0; i < nd; i++) lim = lim * 10;
        for (int i = 0; i < 8; i++) begin
            d[i] = int'(rest % base);
            rest = rest / base;
        end
        for (int i = 0; i < nd; i++) if (d[i] != 0) top = i;
        for (int i = 0; i < nd; i++) begin
            if (!hex && longint'(v) >= lim) r[8*i +: 8] = 8'hBF;
            else if (blank && i > top)      r[8*i +: 8] = 8'hFF;
            else                            r[8*i +: 8] = segTab[d[i]];
        end
        return r;
    endfunction

    function automatic logic modelOvf(input int nd, input logic [23:0] v, input logic hex);
        longint lim;
        lim = 1;
        for (int i = 0; i < nd; i++) lim = lim * 10;
        return !hex && (longint'(v) >= lim);
    endfunction

    // One full load / convert / display case on both instances.
    task automatic runCase(input string tag, input logic [23:0] v, input logic hex,
                           input logic blank, input int expBusy, input logic [63:0] e8,
                           input logic [31:0] e4, input logic eOvf8, input logic eOvf4);
        int c8, c4;
        logic [63:0] r8;
        logic [31:0] r4;
        applyStimulus(v, hex, blank, c8, c4);
        checkOutput({tag, "_busyCycles8"}, c8, expBusy);
        checkOutput({tag, "_busyCycles4"}, c4, expBusy);
        readDigits(r8, r4);
        checkOutput({tag, "_codes8"}, r8, e8);
        checkOutput({tag, "_codes4"}, r4, e4);
        checkOutput({tag, "_ovf8"}, ovf8, eOvf8);
        checkOutput({tag, "_ovf4"}, ovf4, eOvf4);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0]  expDig8;
        logic [3:0]  expDig4;
        logic [63:0] r8, e8;
        logic [31:0] r4, e4;
        logic [23:0] rv;
        logic        rh, rb;
        int          bits, cyc, n;

        segTab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                   8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

        vecs[0] = '{24'd1234,     1'b0, 1'b1, 24, 64'hFFFF_FFFF_F9A4_B099, 32'hF9A4_B099, 1'b0};
        vecs[1] = '{24'hABCDEF,   1'b1, 1'b1,  1, 64'hFFFF_8883_C6A1_868E, 32'hC6A1_868E, 1'b0};
        vecs[2] = '{24'hABCDEF,   1'b1, 1'b0,  1, 64'hC0C0_8883_C6A1_868E, 32'hC6A1_868E, 1'b0};
        vecs[3] = '{24'd10000,    1'b0, 1'b1, 24, 64'hFFFF_FFF9_C0C0_C0C0, 32'hBFBF_BFBF, 1'b1};
        vecs[4] = '{24'd9999,     1'b0, 1'b1, 24, 64'hFFFF_FFFF_9090_9090, 32'h9090_9090, 1'b0};
        vecs[5] = '{24'd0,        1'b0, 1'b1, 24, 64'hFFFF_FFFF_FFFF_FFC0, 32'hFFFF_FFC0, 1'b0};
        vecs[6] = '{24'd0,        1'b1, 1'b0,  1, 64'hC0C0_C0C0_C0C0_C0C0, 32'hC0C0_C0C0, 1'b0};
        vecs[7] = '{24'd16777215, 1'b0, 1'b0, 24, 64'hF982_F8F8_F8A4_F992, 32'hBFBF_BFBF, 1'b1};

        rst      = 1'b1;
        on_off   = 1'b1;
        mode     = 1'b0;
        blank_lz = 1'b0;
        load     = 1'b0;
        value    = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("resetDig8", dig8, 8'hFF);
        checkOutput("resetY8", y8, 8'hFF);
        checkOutput("resetBusy8", busy8, 1'b0);
        checkOutput("resetOvf8", ovf8, 1'b0);
        checkOutput("resetDig4", dig4, 4'hF);
        checkOutput("resetY4", y4, 8'hFF);
        checkOutput("resetBusy4", busy4, 1'b0);
        checkOutput("resetOvf4", ovf4, 1'b0);
        rst = 1'b0;

        // Scan: digit select advances every 10 clocks, one clock behind
        // the index; the cleared display shows '0' everywhere.
        for (n = 1; n <= 170; n++) begin
            @(negedge clk);
            expDig8 = ~(8'd1 << (((n - 1) / 10) % 8));
            expDig4 = ~(4'd1 << (((n - 1) / 10) % 4));
            checkOutput("scanDig8", dig8, expDig8);
            checkOutput("scanDig4", dig4, expDig4);
            checkOutput("scanY8", y8, 8'hC0);
        end

        // Display off: dark from the next edge, scan keeps running.
        on_off = 1'b0;
        for (n = 171; n <= 175; n++) begin
            @(negedge clk);
            checkOutput("offDig8", dig8, 8'hFF);
            checkOutput("offY8", y8, 8'hFF);
            checkOutput("offDig4", dig4, 4'hF);
            checkOutput("offY4", y4, 8'hFF);
        end
        on_off = 1'b1;
        for (n = 176; n <= 185; n++) begin
            @(negedge clk);
            expDig8 = ~(8'd1 << (((n - 1) / 10) % 8));
            expDig4 = ~(4'd1 << (((n - 1) / 10) % 4));
            checkOutput("resumeDig8", dig8, expDig8);
            checkOutput("resumeDig4", dig4, expDig4);
        end

        // Table-driven known cases
        for (int i = 0; i < 8; i++) begin
            runCase($sformatf("vec%0d", i), vecs[i].value, vecs[i].hex, vecs[i].blank,
                    vecs[i].busyCycles, vecs[i].codes8, vecs[i].codes4, 1'b0, vecs[i].ovf4);
        end

        // Load during a conversion is ignored.
        @(negedge clk);
        value = 24'd1234; mode = 1'b0; blank_lz = 1'b1; load = 1'b1;
        cyc = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            load = (c == 3);
            if (c == 3) begin
                value = 24'd5;
                mode  = 1'b1;
            end
            if (c == 4) checkOutput("busyAfterIgnoredLoad", busy8, 1'b1);
            if (busy8) cyc++;
            else break;
        end
        load = 1'b0;
        checkOutput("ignoredLoadBusyCycles", cyc, 24);
        readDigits(r8, r4);
        checkOutput("ignoredLoadCodes8", r8, vecs[0].codes8);
        checkOutput("ignoredLoadCodes4", r4, vecs[0].codes4);

        // Reset in the middle of a conversion aborts it.
        @(negedge clk);
        value = 24'd777777; mode = 1'b0; blank_lz = 1'b1; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("busyBeforeAbort", busy8, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abortBusy8", busy8, 1'b0);
        checkOutput("abortBusy4", busy4, 1'b0);
        repeat (30) @(negedge clk);
        checkOutput("abortStaysIdle", busy8, 1'b0);
        readDigits(r8, r4);
        checkOutput("abortCodes8", r8, 64'hC0C0_C0C0_C0C0_C0C0);
        checkOutput("abortCodes4", r4, 32'hC0C0_C0C0);
        checkOutput("abortOvf4", ovf4, 1'b0);

        // Load held high restarts immediately: hex alternates busy 1/0.
        @(negedge clk);
        value = 24'h00000A; mode = 1'b1; blank_lz = 1'b1; load = 1'b1;
        for (int j = 1; j <= 6; j++) begin
            @(negedge clk);
            checkOutput($sformatf("backToBackBusy%0d", j), busy8, logic'(j % 2));
        end
        load = 1'b0;
        readDigits(r8, r4);
        checkOutput("backToBackCodes8", r8, 64'hFFFF_FFFF_FFFF_FF88);
        checkOutput("backToBackCodes4", r4, 32'hFFFF_FF88);

        // Randomized loads against the reference model
        for (int k = 0; k < 30; k++) begin
            rh   = logic'($urandom_range(0, 1));
            rb   = logic'($urandom_range(0, 1));
            bits = $urandom_range(0, 24);
            rv   = 24'($urandom) & 24'((32'd1 << bits) - 32'd1);
            e8   = modelCodes(8, rv, rh, rb);
            r8   = modelCodes(4, rv, rh, rb);
            e4   = r8[31:0];
            runCase($sformatf("rand%0d_%h_%0d%0d", k, rv, rh, rb), rv, rh, rb, rh ? 1 : 24,
                    e8, e4, modelOvf(8, rv, rh), modelOvf(4, rv, rh));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
